alu_button_sequencer: RTL and testbench
=======================================

Name: alu_button_sequencer

Overview:
- Board-side driver for the worksheet ALU interface: presents a, b and the five one-hot operation lines, then captures the 8-bit ALU result into a held led register.
- On the board, this block drives the ALU the way the simulation bench does: it debounces raw buttons, latches switch operands and sequences each operation.
- Sits between the top-level pins (sw, btn*, led) and the combinational ALU instance.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable samples before a debounced button level changes (>=2).
- SETTLE_CYCLES, 2, cycles the operation lines are held before the ALU result is sampled (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_a  in  8  operand A switches (asynchronous, quasi-static).
- sw_b  in  8  operand B switches.
- btnU_raw, btnL_raw, btnC_raw, btnR_raw, btnD_raw  in  1 each  raw pushbuttons, active-high, bouncing.
- alu_led  in  8  result from the ALU.
- a  out  8  operand A to the ALU.
- b  out  8  operand B to the ALU.
- btnU, btnL, btnC, btnR, btnD  out  1 each  one-hot operation select to the ALU.
- led  out  8  captured result to the LEDs.
- busy  out  1  high from operation accept through capture.
- done  out  1  single-cycle pulse on capture.
- dropped  out  1  single-cycle pulse when a debounced press is discarded.

Behaviour:
- Reset (async assert, sync release): a=b=0, all btn outputs 0, led=0, busy=0, done=0, dropped=0; debounced levels 0, debounce counters 0; FSM IDLE.
- Input sync: each raw button passes through a 2-flop synchronizer. sw_a/sw_b are sampled only when latched; no synchronizer is required.
- Debounce, per button:
  - Counter resets to 0 whenever the synced level equals the debounced level, otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Press = debounced 0->1 transition, a one-cycle event. Release produces no event.
- Arbitration: multiple presses in the same cycle resolve by priority U>L>C>R>D. The winner is accepted (in IDLE); each losing press pulses dropped.
- FSM states IDLE, APPLY, CAPTURE:
  - IDLE: on an accepted press in cycle N:
    - at edge N+1: a<=sw_a, b<=sw_b, winning btn output<=1 (others 0), busy<=1, settle counter<=0, state<=APPLY.
  - APPLY: counter increments each cycle. When counter==SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE (one cycle):
    - led<=alu_led, done<=1 for that edge.
    - All btn outputs<=0, busy<=0, state<=IDLE.
    - a and b keep their latched values.
  - Press-to-led latency: led updates SETTLE_CYCLES+2 edges after the press-event cycle.
- A press while busy=1 (APPLY/CAPTURE) is discarded and pulses dropped. Nothing is queued.
- A press arriving in the same cycle the FSM returns to IDLE is discarded (FSM still in CAPTURE).
- btn outputs are never multi-hot; they are all-zero outside APPLY.
- led holds its value indefinitely between captures.
- Reset mid-operation: immediate return to reset values; the partial operation is lost and led is cleared.

Optional Feature:
- ALU_SEQ_ACCUMULATE_EN.
- Defined:
  - On accept, a<=led (the previous result) instead of sw_a; b still from sw_b. Operations chain.
  - A press on btnC while btnD's debounced level is 1 is a clear instead: no ALU operation, led<=0 and a<=0 in one cycle, done pulses, busy stays 0.
  - btnC with btnD released operates normally.
- Undefined: a always from sw_a; no clear function. Ports are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with sw_a=8'h5A and buttons bouncing -> all outputs 0. Release -> outputs stay 0 until the first debounced press.
- Bounce: btnL_raw toggles every 3 cycles for 40 cycles, then holds 1, with sw_a=8'h12, sw_b=8'h34 and the ALU stub returning 8'h46 -> exactly one operation; btnL=1 for exactly SETTLE_CYCLES+1 cycles; led=8'h46; one done pulse.
- Priority/drop: btnU_raw and btnR_raw rise together and stay stable -> btnU operation runs; dropped pulses once (R); btnR never asserts.
- Busy drop: second debounced press (btnD) lands during APPLY -> dropped pulses; led reflects only the first op; busy falls exactly at CAPTURE.
- Latency: SETTLE_CYCLES=3, press event at cycle N -> btn output high at N+1..N+4; led updates at edge N+5.
- With ALU_SEQ_ACCUMULATE_EN, led=8'h07, btnU op, stub returns a+b, sw_b=8'h01 -> a=8'h07, led=8'h08. A second op then gives 8'h09. Holding btnD then pressing btnC -> led=0.

Source files
------------

// File: rtl/alu_button_sequencer.sv
// alu_button_sequencer: debounces five raw pushbuttons, arbitrates presses
// (U>L>C>R>D), latches switch operands, drives one-hot op lines to an external
// combinational ALU and captures its result into a held LED register.
// Optional build macro: ALU_SEQ_ACCUMULATE_EN (operand A from previous result,
// btnC with btnD held acts as a clear).

// Per-button 2-flop synchronizer plus stability-counter debouncer.
module alu_button_sequencer_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // Synchronize, then flip the level after DEBOUNCE_CYCLES differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module alu_button_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw_a,
    input  logic [7:0] sw_b,
    input  logic       btnU_raw,
    input  logic       btnL_raw,
    input  logic       btnC_raw,
    input  logic       btnR_raw,
    input  logic       btnD_raw,
    input  logic [7:0] alu_led,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       btnU,
    output logic       btnL,
    output logic       btnC,
    output logic       btnR,
    output logic       btnD,
    output logic [7:0] led,
    output logic       busy,
    output logic       done,
    output logic       dropped
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE} state_t;

    // Bit 0 is the highest-priority button so the lowest set bit wins.
    logic [4:0] raw_vec, lvl, lvl_q, press, win, losers;
    logic [4:0] btn, btn_nx;
    logic [7:0] a_nx, b_nx, led_nx, a_src;
    logic       busy_nx, done_nx, dropped_nx, clear_hit;
    logic [SW-1:0] scnt, scnt_nx;
    state_t     state, state_nx;

    assign raw_vec = {btnD_raw, btnR_raw, btnC_raw, btnL_raw, btnU_raw};

    alu_button_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [4:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_vec),
        .level (lvl)
    );

    // Delayed debounced levels for rising-edge (press) detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= '0;
        else        lvl_q <= lvl;
    end

    assign press  = lvl & ~lvl_q;
    assign win    = press & (~press + 5'd1);
    assign losers = press & ~win;

`ifdef ALU_SEQ_ACCUMULATE_EN
    assign clear_hit = win[2] & lvl[4];
    assign a_src     = led;
`else
    assign clear_hit = 1'b0;
    assign a_src     = sw_a;
`endif

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_nx   = state;
        scnt_nx    = scnt;
        a_nx       = a;
        b_nx       = b;
        btn_nx     = btn;
        led_nx     = led;
        busy_nx    = busy;
        done_nx    = 1'b0;
        dropped_nx = 1'b0;
        case (state)
            IDLE: begin
                dropped_nx = |losers;
                if (|win) begin
                    if (clear_hit) begin
                        led_nx  = '0;
                        a_nx    = '0;
                        done_nx = 1'b1;
                    end else begin
                        a_nx     = a_src;
                        b_nx     = sw_b;
                        btn_nx   = win;
                        busy_nx  = 1'b1;
                        scnt_nx  = '0;
                        state_nx = APPLY;
                    end
                end
            end
            APPLY: begin
                dropped_nx = |press;
                scnt_nx    = scnt + 1'b1;
                if (scnt == SW'(SETTLE_CYCLES - 1)) state_nx = CAPTURE;
            end
            CAPTURE: begin
                dropped_nx = |press;
                led_nx     = alu_led;
                done_nx    = 1'b1;
                btn_nx     = '0;
                busy_nx    = 1'b0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            scnt    <= '0;
            a       <= '0;
            b       <= '0;
            btn     <= '0;
            led     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_nx;
            scnt    <= scnt_nx;
            a       <= a_nx;
            b       <= b_nx;
            btn     <= btn_nx;
            led     <= led_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            dropped <= dropped_nx;
        end
    end

    assign {btnD, btnR, btnC, btnL, btnU} = btn;
endmodule

// File: tb/tb_alu_button_sequencer.sv
// Randomized bench for alu_button_sequencer with a cycle-level reference model
// derived from the debounce, arbitration and sequencing rules.
// Honors ALU_SEQ_ACCUMULATE_EN when defined.
module tb_alu_button_sequencer;
    localparam int DEB = 4;
    localparam int SET = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_a, sw_b;
    logic [4:0] raw;              // 0=U 1=L 2=C 3=R 4=D
    logic [7:0] alu_led, a, b, led;
    logic       btnU, btnL, btnC, btnR, btnD, busy, done, dropped;
    logic [4:0] btns;

    int n_chk = 0, n_fail = 0;
    int done_cnt, drop_cnt, l_hi, r_hi;

    always #5 clk = ~clk;

    function automatic logic [7:0] stub(input logic [7:0] x, input logic [7:0] y,
                                        input logic [4:0] op);
        case (op)
            5'b00001: return x + y;
            5'b00010: return x + y;
            5'b00100: return x & y;
            5'b01000: return x | y;
            5'b10000: return x - y;
            default:  return 8'hEE;
        endcase
    endfunction

    assign btns    = {btnD, btnR, btnC, btnL, btnU};
    assign alu_led = stub(a, b, btns);

    alu_button_sequencer #(.DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET)) dut (
        .clk(clk), .rst_n(rst_n), .sw_a(sw_a), .sw_b(sw_b),
        .btnU_raw(raw[0]), .btnL_raw(raw[1]), .btnC_raw(raw[2]),
        .btnR_raw(raw[3]), .btnD_raw(raw[4]),
        .alu_led(alu_led), .a(a), .b(b),
        .btnU(btnU), .btnL(btnL), .btnC(btnC), .btnR(btnR), .btnD(btnD),
        .led(led), .busy(busy), .done(done), .dropped(dropped)
    );

    // Reference model: sync chain, stability streaks, priority pick, op timeline.
    logic [4:0] m_s1, m_s2, m_lvl, m_lvlq, m_btn, pr;
    int         m_streak [5];
    logic [7:0] m_a, m_b, m_led;
    logic       m_busy, m_done, m_drop, m_active, clr;
    int         m_t, w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvlq = 0; m_btn = 0;
            for (int i = 0; i < 5; i++) m_streak[i] = 0;
            m_a = 0; m_b = 0; m_led = 0;
            m_busy = 0; m_done = 0; m_drop = 0; m_active = 0; m_t = 0;
        end else begin
            pr = m_lvl & ~m_lvlq;
            m_done = 0; m_drop = 0;
            if (m_active) begin
                m_drop = |pr;
                m_t++;
                if (m_t == SET + 1) begin
                    m_led = stub(m_a, m_b, m_btn);
                    m_done = 1; m_btn = 0; m_busy = 0; m_active = 0;
                end
            end else begin
                w = -1;
                for (int i = 0; i < 5; i++)
                    if (pr[i]) begin
                        if (w < 0) w = i;
                        else       m_drop = 1;
                    end
                if (w >= 0) begin
`ifdef ALU_SEQ_ACCUMULATE_EN
                    clr = (w == 2) && m_lvl[4];
`else
                    clr = 0;
`endif
                    if (clr) begin
                        m_led = 0; m_a = 0; m_done = 1;
                    end else begin
`ifdef ALU_SEQ_ACCUMULATE_EN
                        m_a = m_led;
`else
                        m_a = sw_a;
`endif
                        m_b = sw_b; m_btn = 5'(1 << w);
                        m_busy = 1; m_active = 1; m_t = 0;
                    end
                end
            end
            m_lvlq = m_lvl;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_lvl[i]) m_streak[i]++;
                else                     m_streak[i] = 0;
                if (m_streak[i] == DEB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_streak[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance n cycles, comparing every output to the model at each negedge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("a", a, m_a);
            chk("b", b, m_b);
            chk("btn", btns, m_btn);
            chk("led", led, m_led);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("dropped", dropped, m_drop);
            done_cnt += done;
            drop_cnt += dropped;
            l_hi += btnL;
            r_hi += btnR;
        end
    endtask

    task automatic clr_cnt();
        done_cnt = 0; drop_cnt = 0; l_hi = 0; r_hi = 0;
    endtask

    task automatic press(input int idx);
        raw[idx] = 1'b1;
        cyc(16);
        raw[idx] = 1'b0;
        cyc(10);
    endtask

    int rise_i, done_i;

    initial begin
        clr_cnt();
        rst_n = 1'b0; raw = '0; sw_a = 8'h5A; sw_b = 8'h00;
        #1;
        for (int k = 0; k < 10; k++) begin
            raw = 5'($urandom);
            cyc(1);
        end
        chk("rst_led", led, 8'h00);
        chk("rst_a", a, 8'h00);
        chk("rst_busy", busy, 0);
        raw = '0;
        rst_n = 1'b1;
        cyc(12);
        chk("idle_led", led, 8'h00);
        chk("idle_done", done_cnt, 0);

        // Bounce on L, then a stable hold.
        sw_a = 8'h12; sw_b = 8'h34; clr_cnt();
        for (int k = 0; k < 40; k++) begin
            raw[1] = ((k / 3) % 2) == 0;
            cyc(1);
        end
        raw[1] = 1'b1;
        cyc(20);
        chk("bounce_done", done_cnt, 1);
        chk("bounce_lhi", l_hi, SET + 1);
`ifndef ALU_SEQ_ACCUMULATE_EN
        chk("bounce_led", led, 8'h46);
`endif
        raw[1] = 1'b0;
        cyc(10);

        // Simultaneous U and R.
        sw_a = 8'h20; sw_b = 8'h05; clr_cnt();
        raw[0] = 1'b1; raw[3] = 1'b1;
        cyc(20);
        chk("prio_done", done_cnt, 1);
        chk("prio_drop", drop_cnt, 1);
        chk("prio_rhi", r_hi, 0);
`ifndef ALU_SEQ_ACCUMULATE_EN
        chk("prio_led", led, 8'h25);
`endif
        raw = '0;
        cyc(10);

        // D press lands while L is being applied.
        sw_a = 8'h30; sw_b = 8'h0F; clr_cnt();
        raw[1] = 1'b1;
        cyc(2);
        raw[4] = 1'b1;
        cyc(20);
        chk("busy_done", done_cnt, 1);
        chk("busy_drop", drop_cnt, 1);
`ifndef ALU_SEQ_ACCUMULATE_EN
        chk("busy_led", led, 8'h3F);
`endif
        raw = '0;
        cyc(10);

        // Latency from op-line rise to done.
        rise_i = -1; done_i = -1;
        raw[3] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            if (btnR && rise_i < 0) rise_i = k;
            if (done && done_i < 0) done_i = k;
        end
        chk("lat_found", (rise_i >= 0) && (done_i >= 0), 1);
        chk("lat", done_i - rise_i, SET + 1);
        raw = '0;
        cyc(10);

        // Reset in the middle of an operation.
        raw[1] = 1'b1;
        cyc(8);
        rst_n = 1'b0;
        cyc(2);
        chk("midrst_led", led, 8'h00);
        chk("midrst_btn", btns, 5'h00);
        raw = '0;
        rst_n = 1'b1;
        cyc(10);

`ifdef ALU_SEQ_ACCUMULATE_EN
        sw_b = 8'h07; press(0);
        chk("acc_first", led, 8'h07);
        sw_b = 8'h01; press(0);
        chk("acc_a", a, 8'h07);
        chk("acc_second", led, 8'h08);
        press(0);
        chk("acc_third", led, 8'h09);
        raw[4] = 1'b1;
        cyc(16);
        clr_cnt();
        press(2);
        chk("acc_clear", led, 8'h00);
        chk("acc_clear_done", done_cnt, 1);
        raw = '0;
        cyc(10);
`endif

        // Random buttons and switches with an occasional reset.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 11) == 0) raw[i] = ~raw[i];
            if ($urandom_range(0, 19) == 0) sw_a = 8'($urandom);
            if ($urandom_range(0, 19) == 0) sw_b = 8'($urandom);
            if (k == 1500) rst_n = 1'b0;
            if (k == 1502) rst_n = 1'b1;
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
